// File: rtl/ps2_key_ctrl_if.sv
// Byte-in / direction-out stream bundle for ps2_key_ctrl.
// The slave modport is the controller side; master is the byte source and command consumer.
interface ps2_key_ctrl_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       dir_valid;
  logic [1:0] dir_data;
  logic       dir_ready;

  modport slave  (input  byte_valid, byte_data, dir_ready,
                  output dir_valid, dir_data);
  modport master (output byte_valid, byte_data, dir_ready,
                  input  dir_valid, dir_data);
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code decoder turning arrow/WASD make/break codes into a direction-command FIFO.
// Optional macro SNAKE_NO_REVERSE_EN suppresses pushes that reverse the last pushed direction.
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  ps2_key_ctrl_if.slave       bus,
  output logic [3:0]          held,
  output logic [7:0]          last_code,
  output logic                overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMAX_C  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_held;
  logic [7:0]    r_last_code;
  logic          r_overflow;
  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  logic       w_make, w_brk, w_ext, w_timeout;
  logic       w_hit, w_make_new, w_push, w_pop, w_wr, w_rev_block;
  logic [1:0] w_dir;

  // {hit, dir}: dir encodes 00 up, 01 down, 10 left, 11 right
  function automatic logic [2:0] dir_decode(input logic ext, input logic [7:0] code);
    logic [2:0] r;
    r = 3'b000;
    if (ext) begin
      case (code)
        8'h75:   r = 3'b100;
        8'h72:   r = 3'b101;
        8'h6B:   r = 3'b110;
        8'h74:   r = 3'b111;
        default: r = 3'b000;
      endcase
    end else begin
      case (code)
        8'h1D:   r = 3'b100;
        8'h1B:   r = 3'b101;
        8'h1C:   r = 3'b110;
        8'h23:   r = 3'b111;
        default: r = 3'b000;
      endcase
    end
    return r;
  endfunction

  assign w_timeout = (r_state != IDLE) && !bus.byte_valid && (r_tcnt == TMAX_C);

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    if (bus.byte_valid) begin
      case (r_state)
        IDLE: begin
          if (bus.byte_data == 8'hE0)      w_state_nxt = EXT;
          else if (bus.byte_data == 8'hF0) w_state_nxt = BRK;
          else                             w_make      = 1'b1;
        end
        EXT: begin
          if (bus.byte_data == 8'hF0)      w_state_nxt = EXT_BRK;
          else if (bus.byte_data == 8'hE0) w_state_nxt = EXT;
          else begin
            w_make      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        BRK: begin
          w_brk       = 1'b1;
          w_state_nxt = IDLE;
        end
        default: begin
          w_brk       = 1'b1;
          w_ext       = 1'b1;
          w_state_nxt = IDLE;
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              r_tcnt <= '0;
    else if (bus.byte_valid || r_state == IDLE || w_timeout) r_tcnt <= '0;
    else                                                     r_tcnt <= r_tcnt + 1'b1;
  end

  assign {w_hit, w_dir} = dir_decode(w_ext, bus.byte_data);
  assign w_make_new     = w_make && w_hit && !r_held[w_dir];
  assign w_push         = w_make_new && !w_rev_block;
  assign w_pop          = (r_count != '0) && bus.dir_ready;
  assign w_wr           = w_push && ((r_count != DEPTH_C) || w_pop);

`ifdef SNAKE_NO_REVERSE_EN
  logic       r_last_vld;
  logic [1:0] r_last_dir;

  // Opposite directions differ only in the low bit of the encoding
  assign w_rev_block = r_last_vld && (w_dir == (r_last_dir ^ 2'b01));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_vld <= 1'b0;
      r_last_dir <= 2'b00;
    end else if (w_wr) begin
      r_last_vld <= 1'b1;
      r_last_dir <= w_dir;
    end
  end
`else
  assign w_rev_block = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held      <= 4'b0000;
      r_last_code <= 8'h00;
      r_overflow  <= 1'b0;
    end else begin
      if (bus.byte_valid)      r_last_code   <= bus.byte_data;
      if (w_make_new)          r_held[w_dir] <= 1'b1;
      else if (w_brk && w_hit) r_held[w_dir] <= 1'b0;
      if (w_push && !w_wr)     r_overflow    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only; occupancy gating keeps the head at 00 when empty
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_dir;
  end

  assign bus.dir_valid = (r_count != '0);
  assign bus.dir_data  = (r_count != '0) ? r_mem[r_rptr] : 2'b00;
  assign held          = r_held;
  assign last_code     = r_last_code;
  assign overflow      = r_overflow;

endmodule
